// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the issuing controller and seq_divider.
// The master drives the operands; the slave returns the results.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero,
    input  quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero,
    output quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider.
// Each quotient bit takes one SHIFT step followed by one SUB step.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_SUB   = 2'd2;
  localparam logic [1:0] ST_END   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    count;
  logic             dbz;
  logic [WIDTH:0]   diff;

  assign diff = a - {1'b0, m};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      count <= '0;
      dbz   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            m     <= bus.divisor;
            count <= CNT_INIT;
            if (bus.divisor == '0) begin
              dbz   <= 1'b1;
              q     <= '1;
              a     <= {1'b0, bus.dividend};
              state <= ST_END;
            end else begin
              dbz   <= 1'b0;
              q     <= bus.dividend;
              a     <= '0;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          {a, q} <= {a[WIDTH-1:0], q, 1'b0};
          state  <= ST_SUB;
        end
        ST_SUB: begin
          // negative trial difference means restore: keep A, Q[0] stays 0
          if (!diff[WIDTH]) begin
            a    <= diff;
            q[0] <= 1'b1;
          end
          count <= count - CNT_ONE;
          state <= (count == CNT_ONE) ? ST_END : ST_SHIFT;
        end
        ST_END: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = (state == ST_SHIFT) || (state == ST_SUB);
  assign bus.done        = (state == ST_END);
  assign bus.div_by_zero = dbz;
  assign bus.quotient    = q;
  assign bus.remainder   = a[WIDTH-1:0];
endmodule
